snake_body_engine: RTL and testbench
====================================

SNAKE_BODY_ENGINE -- requirements
Module: snake_body_engine

Interface
REQ-001 Parameter GRID_W, default 16, grid columns; X range 0..GRID_W-1.
REQ-002 Parameter GRID_H, default 16, grid rows; Y range 0..GRID_H-1.
REQ-003 Parameter MAX_LEN, default 64, body buffer depth; not required to be a power of 2.
REQ-004 Parameter INIT_LEN, default 3, length after reset or Start (2..MAX_LEN-1).
REQ-005 Parameters XW/YW/LW, defaults 4/4/7, coordinate and length widths.
REQ-006 Clk  in  1  rising-edge clock.
REQ-007 Reset  in  1  asynchronous, active-high.
REQ-008 Start  in  1  one-cycle pulse; (re)initialise and enter RUN.
REQ-009 Step  in  1  one-cycle move tick.
REQ-010 Dir_Valid  in  1  qualifies Dir_In.
REQ-011 Dir_In  in  2  00 up (Y+1), 01 down (Y-1), 10 left (X-1), 11 right (X+1).
REQ-012 Apple_X/Apple_Y  in  XW/YW  current apple cell.
REQ-013 Head_X/Head_Y, Tail_X/Tail_Y  out  XW/YW  current head and tail cells.
REQ-014 Length  out  LW  current segment count.
REQ-015 Occ_Map  out  GRID_W*GRID_H  occupancy bitmap; bit index X*GRID_H+Y.
REQ-016 Ate  out  1  one-cycle pulse after a growth step.
REQ-017 Running/Dead/Win  out  1  level flags for RUN/LOSE/WIN.

Function
REQ-018 FSM states IDLE, RUN, LOSE, WIN; exactly one of Running/Dead/Win high in RUN/LOSE/WIN, all low in IDLE.
REQ-019 Transitions: IDLE/LOSE/WIN --Start--> RUN; RUN --collision--> LOSE; RUN --growth reaching MAX_LEN or GRID_W*GRID_H--> WIN; Start in RUN ignored.
REQ-020 Init (reset or Start): head (GRID_W/2, GRID_H/2), body vertical down to tail (GRID_W/2, GRID_H/2-INIT_LEN+1), Length=INIT_LEN, Cur_Dir=Pend_Dir=up, Occ_Map exactly the INIT_LEN body bits, all in one cycle.
REQ-021 Body held in MAX_LEN-entry circular buffer, head/tail pointers increment modulo MAX_LEN, wrap MAX_LEN-1 -> 0.
REQ-022 Dir_Valid in RUN latches Dir_In into Pend_Dir unless it is the 180-degree reverse of Cur_Dir (ignored); later valid inputs overwrite earlier ones.
REQ-023 Dir_Valid and Step in same cycle: Dir_In (if legal) governs that step.
REQ-024 Step in RUN: next head = head moved by Pend_Dir; Cur_Dir <= Pend_Dir; all outputs update at that edge, visible next cycle.
REQ-025 Wall collision: next cell outside grid (no wrap-around) -> LOSE.
REQ-026 Self collision: Occ_Map bit of next cell set -> LOSE, except next == current tail on a non-growth step (legal).
REQ-027 On collision, body, pointers, Length, head, tail and Occ_Map unchanged.
REQ-028 Growth step (next == apple, no collision): push head, tail kept, Length+1, Ate=1 for one cycle, set head bit.
REQ-029 Move step: push head, pop tail, Tail <= new oldest entry, clear old tail bit then set new head bit (bit stays set when next == old tail).
REQ-030 Step outside RUN, and Step on Start cycle, ignored; Start has priority.
REQ-031 Ate low except the single cycle after a growth step; Length never exceeds MAX_LEN.

Reset
REQ-032 Reset asserted at any time, including mid-step, forces IDLE and the REQ-020 init values asynchronously; Ate=0, all flags low.
REQ-033 First Step accepted only after Reset deassertion and a Start pulse.

Verification (defaults 16x16, MAX_LEN 64, INIT_LEN 3)
REQ-034 Reset -> head (8,8), tail (8,6), Length 3, Occ_Map bits 134/135/136 only, all flags 0; Start -> Running=1.
REQ-035 Apple (8,9), Step -> head (8,9), tail (8,6), Length 4, Ate pulse one cycle, bit 137 set.
REQ-036 Apple (0,0), Step -> head (8,9), tail (8,7), bit 134 cleared, Length 3; Dir_In=down with Step -> ignored, head (8,10).
REQ-037 Steps up until head (8,15), one more Step -> Dead=1, head stays (8,15), further Steps no effect, Start -> re-init per REQ-034 and Running=1.
REQ-038 Length 4 square (head (8,9) dir left into tail cell) -> legal, no Dead; Length 5 U-turn into own neck -> Dead=1.
REQ-039 MAX_LEN=4 build: one growth Step -> Length 4, Win=1, Ate pulse; 70 move Steps with MAX_LEN=5 -> pointer wrap, Occ_Map popcount stays Length.

Source files
------------

// File: rtl/snake_body_engine.sv
// Snake game body engine: circular body buffer, occupancy bitmap, move/grow/collide
// sequencing and the IDLE/RUN/LOSE/WIN game state.
module snake_body_engine #(
    parameter int GRID_W   = 16,
    parameter int GRID_H   = 16,
    parameter int MAX_LEN  = 64,
    parameter int INIT_LEN = 3,
    parameter int XW       = 4,
    parameter int YW       = 4,
    parameter int LW       = 7
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     Start,
    input  logic                     Step,
    input  logic                     Dir_Valid,
    input  logic [1:0]               Dir_In,
    input  logic [XW-1:0]            Apple_X,
    input  logic [YW-1:0]            Apple_Y,
    output logic [XW-1:0]            Head_X,
    output logic [YW-1:0]            Head_Y,
    output logic [XW-1:0]            Tail_X,
    output logic [YW-1:0]            Tail_Y,
    output logic [LW-1:0]            Length,
    output logic [GRID_W*GRID_H-1:0] Occ_Map,
    output logic                     Ate,
    output logic                     Running,
    output logic                     Dead,
    output logic                     Win
);
    localparam int CELLS = GRID_W * GRID_H;
    localparam int IW    = $clog2(CELLS);
    localparam int PW    = $clog2(MAX_LEN);
    localparam logic [XW-1:0] HX = XW'(GRID_W / 2);
    localparam logic [YW-1:0] HY = YW'(GRID_H / 2);
    localparam logic [YW-1:0] TY = YW'(GRID_H / 2 - INIT_LEN + 1);
    localparam logic [1:0] D_UP = 2'd0, D_DN = 2'd1, D_LF = 2'd2, D_RT = 2'd3;

    function automatic logic [CELLS-1:0] init_occ();
        logic [CELLS-1:0] m;
        m = '0;
        for (int i = 0; i < INIT_LEN; i++)
            m = m | (CELLS'(1) << ((GRID_W / 2) * GRID_H + GRID_H / 2 - i));
        return m;
    endfunction

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_LEN - 1)) ? '0 : p + PW'(1);
    endfunction

    localparam logic [CELLS-1:0] OCC_INIT = init_occ();

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_LOSE, S_WIN} state_t;
    state_t r_state, w_state_nxt;

    logic [XW-1:0]    r_body_x [MAX_LEN];
    logic [YW-1:0]    r_body_y [MAX_LEN];
    logic [PW-1:0]    r_hd_ptr, r_tl_ptr;
    logic [XW-1:0]    r_head_x, r_tail_x;
    logic [YW-1:0]    r_head_y, r_tail_y;
    logic [LW-1:0]    r_len;
    logic [CELLS-1:0] r_occ;
    logic [1:0]       r_cur_dir, r_pend_dir;
    logic             r_ate;

    logic             w_init, w_do_step, w_dir_ok, w_wall, w_hit, w_at_tail;
    logic             w_grow, w_collide, w_full;
    logic [1:0]       w_dir;
    logic [XW-1:0]    w_nx;
    logic [YW-1:0]    w_ny;
    logic [IW-1:0]    w_nidx, w_tidx;
    logic [CELLS-1:0] w_head_bit, w_tail_bit;
    logic [PW-1:0]    w_hd_nxt, w_tl_nxt;

    assign w_init    = Start && (r_state != S_RUN);
    assign w_do_step = Step && !Start && (r_state == S_RUN);
    // A direction equal to the reverse of the current heading is dropped.
    assign w_dir_ok  = Dir_Valid && (Dir_In != {r_cur_dir[1], ~r_cur_dir[0]});
    assign w_dir     = w_dir_ok ? Dir_In : r_pend_dir;

    always_comb begin
        w_nx   = r_head_x;
        w_ny   = r_head_y;
        w_wall = 1'b0;
        case (w_dir)
            D_UP: begin w_wall = (r_head_y == YW'(GRID_H - 1)); w_ny = r_head_y + YW'(1); end
            D_DN: begin w_wall = (r_head_y == '0);               w_ny = r_head_y - YW'(1); end
            D_LF: begin w_wall = (r_head_x == '0);               w_nx = r_head_x - XW'(1); end
            default: begin w_wall = (r_head_x == XW'(GRID_W - 1)); w_nx = r_head_x + XW'(1); end
        endcase
    end

    assign w_nidx     = IW'(int'(w_nx) * GRID_H + int'(w_ny));
    assign w_tidx     = IW'(int'(r_tail_x) * GRID_H + int'(r_tail_y));
    assign w_head_bit = CELLS'(1) << w_nidx;
    assign w_tail_bit = CELLS'(1) << w_tidx;
    assign w_hit      = r_occ[w_nidx];
    assign w_at_tail  = (w_nx == r_tail_x) && (w_ny == r_tail_y);
    assign w_grow     = (w_nx == Apple_X) && (w_ny == Apple_Y);
    // Entering the tail cell is legal only when the tail is about to move away.
    assign w_collide  = w_wall || (w_hit && !(w_at_tail && !w_grow));
    assign w_full     = (int'(r_len) + 1 == MAX_LEN) || (int'(r_len) + 1 == CELLS);
    assign w_hd_nxt   = ptr_inc(r_hd_ptr);
    assign w_tl_nxt   = ptr_inc(r_tl_ptr);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_RUN: begin
                if (w_do_step && w_collide)             w_state_nxt = S_LOSE;
                else if (w_do_step && w_grow && w_full) w_state_nxt = S_WIN;
            end
            default: if (Start) w_state_nxt = S_RUN;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                r_body_x[PW'(i)] <= (i < INIT_LEN) ? HX : '0;
                r_body_y[PW'(i)] <= (i < INIT_LEN) ? YW'(GRID_H / 2 - INIT_LEN + 1 + i) : '0;
            end
            r_hd_ptr   <= PW'(INIT_LEN - 1);
            r_tl_ptr   <= '0;
            r_head_x   <= HX;
            r_head_y   <= HY;
            r_tail_x   <= HX;
            r_tail_y   <= TY;
            r_len      <= LW'(INIT_LEN);
            r_occ      <= OCC_INIT;
            r_cur_dir  <= D_UP;
            r_pend_dir <= D_UP;
            r_ate      <= 1'b0;
        end else begin
            r_ate <= 1'b0;
            if (w_init) begin
                for (int i = 0; i < MAX_LEN; i++) begin
                    r_body_x[PW'(i)] <= (i < INIT_LEN) ? HX : '0;
                    r_body_y[PW'(i)] <= (i < INIT_LEN) ? YW'(GRID_H / 2 - INIT_LEN + 1 + i) : '0;
                end
                r_hd_ptr   <= PW'(INIT_LEN - 1);
                r_tl_ptr   <= '0;
                r_head_x   <= HX;
                r_head_y   <= HY;
                r_tail_x   <= HX;
                r_tail_y   <= TY;
                r_len      <= LW'(INIT_LEN);
                r_occ      <= OCC_INIT;
                r_cur_dir  <= D_UP;
                r_pend_dir <= D_UP;
            end else if (r_state == S_RUN) begin
                if (w_dir_ok) r_pend_dir <= Dir_In;
                if (w_do_step && !w_collide) begin
                    r_cur_dir          <= w_dir;
                    r_pend_dir         <= w_dir;
                    r_hd_ptr           <= w_hd_nxt;
                    r_body_x[w_hd_nxt] <= w_nx;
                    r_body_y[w_hd_nxt] <= w_ny;
                    r_head_x           <= w_nx;
                    r_head_y           <= w_ny;
                    if (w_grow) begin
                        r_len <= r_len + LW'(1);
                        r_occ <= r_occ | w_head_bit;
                        r_ate <= 1'b1;
                    end else begin
                        r_tl_ptr <= w_tl_nxt;
                        r_tail_x <= r_body_x[w_tl_nxt];
                        r_tail_y <= r_body_y[w_tl_nxt];
                        // Clear before set so a head landing on the old tail stays marked.
                        r_occ    <= (r_occ & ~w_tail_bit) | w_head_bit;
                    end
                end
            end
        end
    end

    assign Head_X  = r_head_x;
    assign Head_Y  = r_head_y;
    assign Tail_X  = r_tail_x;
    assign Tail_Y  = r_tail_y;
    assign Length  = r_len;
    assign Occ_Map = r_occ;
    assign Ate     = r_ate;
    assign Running = (r_state == S_RUN);
    assign Dead    = (r_state == S_LOSE);
    assign Win     = (r_state == S_WIN);
endmodule

// File: tb/tb_snake_body_engine.sv
// Bench for snake_body_engine: directed vector table, a queue-based game model under
// random play, async reset, and small-buffer win / pointer-wrap sequences.
module tb_snake_body_engine;
    localparam int N = 256;
    localparam int M_IDLE = 0, M_RUN = 1, M_LOSE = 2, M_WIN = 3;

    logic Clk = 1'b0;
    logic Reset;
    logic Start, Step, Dir_Valid;
    logic [1:0] Dir_In;
    logic [3:0] Apple_X, Apple_Y;
    logic [3:0] Head_X, Head_Y, Tail_X, Tail_Y;
    logic [6:0] Length;
    logic [N-1:0] Occ_Map;
    logic Ate, Running, Dead, Win;

    logic Start2, Step2, Step3, Dv2;
    logic [1:0] Dir2;
    logic [3:0] b_hx, b_hy, b_tx, b_ty, c_hx, c_hy, c_tx, c_ty;
    logic [6:0] b_len, c_len;
    logic [N-1:0] b_occ, c_occ;
    logic b_ate, b_run, b_dead, b_win, c_ate, c_run, c_dead, c_win;

    always #5 Clk = ~Clk;

    snake_body_engine u_dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Step(Step), .Dir_Valid(Dir_Valid),
        .Dir_In(Dir_In), .Apple_X(Apple_X), .Apple_Y(Apple_Y),
        .Head_X(Head_X), .Head_Y(Head_Y), .Tail_X(Tail_X), .Tail_Y(Tail_Y),
        .Length(Length), .Occ_Map(Occ_Map), .Ate(Ate),
        .Running(Running), .Dead(Dead), .Win(Win));

    snake_body_engine #(.MAX_LEN(4)) u_win4 (
        .Clk(Clk), .Reset(Reset), .Start(Start2), .Step(Step2), .Dir_Valid(Dv2),
        .Dir_In(Dir2), .Apple_X(4'd8), .Apple_Y(4'd9),
        .Head_X(b_hx), .Head_Y(b_hy), .Tail_X(b_tx), .Tail_Y(b_ty),
        .Length(b_len), .Occ_Map(b_occ), .Ate(b_ate),
        .Running(b_run), .Dead(b_dead), .Win(b_win));

    snake_body_engine #(.MAX_LEN(5)) u_wrap5 (
        .Clk(Clk), .Reset(Reset), .Start(Start2), .Step(Step3), .Dir_Valid(Dv2),
        .Dir_In(Dir2), .Apple_X(4'd0), .Apple_Y(4'd0),
        .Head_X(c_hx), .Head_Y(c_hy), .Tail_X(c_tx), .Tail_Y(c_ty),
        .Length(c_len), .Occ_Map(c_occ), .Ate(c_ate),
        .Running(c_run), .Dead(c_dead), .Win(c_win));

    int vecs = 0;
    int fails = 0;

    // Reference game: body as a queue of cells, index 0 = tail, last = head.
    int mx[$];
    int my[$];
    int mstate, mcur, mpend, mate;

    task automatic m_init();
        mx.delete();
        my.delete();
        for (int i = 0; i < 3; i++) begin
            mx.push_back(8);
            my.push_back(6 + i);
        end
        mcur = 0;
        mpend = 0;
        mate = 0;
    endtask

    function automatic int rev(input int d);
        case (d)
            0: return 1;
            1: return 0;
            2: return 3;
            default: return 2;
        endcase
    endfunction

    function automatic int eff_dir(input int dv, input int d);
        if (dv != 0 && d != rev(mcur)) return d;
        return mpend;
    endfunction

    task automatic m_clock(input int st, input int sp, input int dv, input int d,
                           input int ax, input int ay);
        int eff, nx, ny, grow, hit;
        mate = 0;
        if (st != 0 && mstate != M_RUN) begin
            m_init();
            mstate = M_RUN;
            return;
        end
        if (mstate != M_RUN) return;
        eff = eff_dir(dv, d);
        mpend = eff;
        if (sp == 0 || st != 0) return;
        nx = mx[mx.size()-1];
        ny = my[my.size()-1];
        case (eff)
            0: ny = ny + 1;
            1: ny = ny - 1;
            2: nx = nx - 1;
            default: nx = nx + 1;
        endcase
        if (nx < 0 || nx > 15 || ny < 0 || ny > 15) begin
            mstate = M_LOSE;
            return;
        end
        grow = (nx == ax && ny == ay) ? 1 : 0;
        hit = 0;
        for (int i = 0; i < mx.size(); i++)
            if (mx[i] == nx && my[i] == ny && !(i == 0 && grow == 0)) hit = 1;
        if (hit != 0) begin
            mstate = M_LOSE;
            return;
        end
        mx.push_back(nx);
        my.push_back(ny);
        mcur = eff;
        if (grow != 0) begin
            mate = 1;
            if (mx.size() == 64 || mx.size() == 256) mstate = M_WIN;
        end else begin
            void'(mx.pop_front());
            void'(my.pop_front());
        end
    endtask

    function automatic logic [N-1:0] m_occ();
        logic [N-1:0] o;
        o = '0;
        for (int i = 0; i < mx.size(); i++) o = o | (N'(1) << (mx[i] * 16 + my[i]));
        return o;
    endfunction

    task automatic check_main(input string nm);
        logic [N-1:0] eo;
        int k;
        bit ok;
        eo = m_occ();
        k = mx.size() - 1;
        ok = (int'(Head_X) == mx[k]) && (int'(Head_Y) == my[k]) &&
             (int'(Tail_X) == mx[0]) && (int'(Tail_Y) == my[0]) &&
             (int'(Length) == mx.size()) && (Occ_Map === eo) &&
             (int'(Ate) == mate) && (Running === (mstate == M_RUN)) &&
             (Dead === (mstate == M_LOSE)) && (Win === (mstate == M_WIN));
        vecs++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: got head=(%0d,%0d) tail=(%0d,%0d) len=%0d ate=%0b run/dead/win=%0b%0b%0b occ_match=%0b; want head=(%0d,%0d) tail=(%0d,%0d) len=%0d ate=%0d state=%0d",
                     nm, Head_X, Head_Y, Tail_X, Tail_Y, Length, Ate, Running, Dead, Win,
                     Occ_Map === eo, mx[k], my[k], mx[0], my[0], mx.size(), mate, mstate);
        end
    endtask

    task automatic expect_int(input string nm, input int got, input int want);
        vecs++;
        if (got != want) begin
            fails++;
            $display("FAIL %s: got %0d want %0d", nm, got, want);
        end
    endtask

    task automatic check_init(input string nm);
        logic [N-1:0] eo;
        eo = '0;
        eo[134] = 1'b1;
        eo[135] = 1'b1;
        eo[136] = 1'b1;
        vecs++;
        if (!(Head_X == 4'd8 && Head_Y == 4'd8 && Tail_X == 4'd8 && Tail_Y == 4'd6 &&
              Length == 7'd3 && Occ_Map === eo && !Ate && !Running && !Dead && !Win)) begin
            fails++;
            $display("FAIL %s: got head=(%0d,%0d) tail=(%0d,%0d) len=%0d flags=%0b%0b%0b%0b occ_ok=%0b; want (8,8) (8,6) 3 0000 1",
                     nm, Head_X, Head_Y, Tail_X, Tail_Y, Length, Ate, Running, Dead, Win, Occ_Map === eo);
        end
    endtask

    task automatic cyc(input int st, input int sp, input int dv, input int d,
                       input int ax, input int ay, input string nm);
        @(negedge Clk);
        Start = 1'(st);
        Step = 1'(sp);
        Dir_Valid = 1'(dv);
        Dir_In = 2'(d);
        Apple_X = 4'(ax);
        Apple_Y = 4'(ay);
        @(posedge Clk);
        m_clock(st, sp, dv, d, ax, ay);
        #1;
        check_main(nm);
        Start = 1'b0;
        Step = 1'b0;
        Dir_Valid = 1'b0;
    endtask

    typedef struct {
        int st, sp, dv, d, ax, ay;
        int hx, hy, tx, ty, len, ate, run, dead;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input int st, input int sp, input int dv, input int d, input int ax, input int ay,
                       input int hx, input int hy, input int tx, input int ty, input int len,
                       input int ate, input int run, input int dead);
        vec_t v;
        v = '{st, sp, dv, d, ax, ay, hx, hy, tx, ty, len, ate, run, dead};
        tbl.push_back(v);
    endtask

    function automatic int walk_dir(input int k);
        case (k % 4)
            0: return 3;
            1: return 1;
            2: return 2;
            default: return 0;
        endcase
    endfunction

    initial begin
        int st, sp, dv, d, ax, ay, nx, ny, e;
        Reset = 1'b1;
        Start = 1'b0; Step = 1'b0; Dir_Valid = 1'b0; Dir_In = 2'd0;
        Apple_X = 4'd0; Apple_Y = 4'd0;
        Start2 = 1'b0; Step2 = 1'b0; Step3 = 1'b0; Dv2 = 1'b0; Dir2 = 2'd0;
        m_init();
        mstate = M_IDLE;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        #1;
        check_init("reset_state");
        cyc(0, 1, 0, 0, 0, 0, "step_before_start");

        //   st sp dv d  ax ay   hx hy tx ty len ate run dead
        add(1, 0, 0, 0, 0, 0,   8, 8, 8, 6, 3, 0, 1, 0);
        add(0, 1, 0, 0, 0, 0,   8, 9, 8, 7, 3, 0, 1, 0);
        add(0, 1, 1, 1, 0, 0,   8, 10, 8, 8, 3, 0, 1, 0);
        add(0, 1, 0, 0, 8, 11,  8, 11, 8, 8, 4, 1, 1, 0);
        add(0, 0, 0, 0, 0, 0,   8, 11, 8, 8, 4, 0, 1, 0);
        add(0, 1, 0, 0, 0, 0,   8, 12, 8, 9, 4, 0, 1, 0);
        add(0, 1, 0, 0, 0, 0,   8, 13, 8, 10, 4, 0, 1, 0);
        add(0, 1, 0, 0, 0, 0,   8, 14, 8, 11, 4, 0, 1, 0);
        add(0, 1, 0, 0, 0, 0,   8, 15, 8, 12, 4, 0, 1, 0);
        add(0, 1, 0, 0, 0, 0,   8, 15, 8, 12, 4, 0, 0, 1);
        add(0, 1, 0, 0, 0, 0,   8, 15, 8, 12, 4, 0, 0, 1);
        add(1, 0, 0, 0, 0, 0,   8, 8, 8, 6, 3, 0, 1, 0);
        add(0, 1, 0, 0, 8, 9,   8, 9, 8, 6, 4, 1, 1, 0);
        add(0, 1, 1, 3, 0, 0,   9, 9, 8, 7, 4, 0, 1, 0);
        add(0, 1, 1, 1, 0, 0,   9, 8, 8, 8, 4, 0, 1, 0);
        add(0, 1, 1, 2, 0, 0,   8, 8, 8, 9, 4, 0, 1, 0);
        add(0, 1, 1, 0, 0, 0,   8, 9, 9, 9, 4, 0, 1, 0);
        add(0, 1, 0, 0, 8, 10,  8, 10, 9, 9, 5, 1, 1, 0);
        add(0, 1, 1, 3, 0, 0,   9, 10, 9, 8, 5, 0, 1, 0);
        add(0, 1, 1, 1, 0, 0,   9, 9, 8, 8, 5, 0, 1, 0);
        add(0, 1, 1, 2, 0, 0,   9, 9, 8, 8, 5, 0, 0, 1);

        for (int i = 0; i < tbl.size(); i++) begin
            cyc(tbl[i].st, tbl[i].sp, tbl[i].dv, tbl[i].d, tbl[i].ax, tbl[i].ay, "model_tbl");
            vecs++;
            if (!(int'(Head_X) == tbl[i].hx && int'(Head_Y) == tbl[i].hy &&
                  int'(Tail_X) == tbl[i].tx && int'(Tail_Y) == tbl[i].ty &&
                  int'(Length) == tbl[i].len && int'(Ate) == tbl[i].ate &&
                  int'(Running) == tbl[i].run && int'(Dead) == tbl[i].dead &&
                  $countones(Occ_Map) == tbl[i].len)) begin
                fails++;
                $display("FAIL tbl[%0d]: got head=(%0d,%0d) tail=(%0d,%0d) len=%0d ate=%0b run=%0b dead=%0b pop=%0d; want (%0d,%0d) (%0d,%0d) %0d %0d %0d %0d",
                         i, Head_X, Head_Y, Tail_X, Tail_Y, Length, Ate, Running, Dead,
                         $countones(Occ_Map), tbl[i].hx, tbl[i].hy, tbl[i].tx, tbl[i].ty,
                         tbl[i].len, tbl[i].ate, tbl[i].run, tbl[i].dead);
            end
        end

        // Asynchronous reset landing in the middle of a step cycle.
        cyc(1, 0, 0, 0, 0, 0, "restart");
        cyc(0, 1, 0, 0, 0, 0, "pre_reset_step");
        @(negedge Clk);
        Step = 1'b1;
        #2 Reset = 1'b1;
        #1 check_init("async_reset");
        m_init();
        mstate = M_IDLE;
        @(posedge Clk);
        #1 check_main("reset_held");
        @(negedge Clk);
        Reset = 1'b0;
        Step = 1'b0;
        cyc(0, 1, 0, 0, 0, 0, "step_after_reset");

        for (int n = 0; n < 3000; n++) begin
            st = (mstate != M_RUN) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 60) == 0);
            sp = $urandom_range(0, 1);
            dv = ($urandom_range(0, 2) == 0);
            d  = $urandom_range(0, 3);
            ax = $urandom_range(0, 15);
            ay = $urandom_range(0, 15);
            if (mstate == M_RUN && $urandom_range(0, 2) == 0) begin
                e  = eff_dir(dv, d);
                nx = mx[mx.size()-1] + ((e == 3) ? 1 : (e == 2) ? -1 : 0);
                ny = my[my.size()-1] + ((e == 0) ? 1 : (e == 1) ? -1 : 0);
                if (nx >= 0 && nx <= 15 && ny >= 0 && ny <= 15) begin
                    ax = nx;
                    ay = ny;
                end
            end
            cyc(st, sp, dv, d, ax, ay, "random");
        end

        // MAX_LEN=4 grows straight into WIN; MAX_LEN=5 circles a 2x2 loop to wrap pointers.
        @(negedge Clk);
        Start2 = 1'b1;
        @(posedge Clk);
        #1;
        expect_int("win4_run", int'(b_run), 1);
        expect_int("wrap5_run", int'(c_run), 1);
        @(negedge Clk);
        Start2 = 1'b0;
        Step2 = 1'b1;
        @(posedge Clk);
        #1;
        expect_int("win4_len", int'(b_len), 4);
        expect_int("win4_win", int'(b_win), 1);
        expect_int("win4_ate", int'(b_ate), 1);
        expect_int("win4_run_low", int'(b_run), 0);
        expect_int("win4_head_y", int'(b_hy), 9);
        expect_int("wrap5_idle_len", int'(c_len), 3);
        @(negedge Clk);
        Step2 = 1'b0;
        @(posedge Clk);
        #1;
        expect_int("win4_ate_drop", int'(b_ate), 0);
        expect_int("win4_win_hold", int'(b_win), 1);
        for (int k = 0; k < 70; k++) begin
            @(negedge Clk);
            Step3 = 1'b1;
            Dv2 = 1'b1;
            Dir2 = 2'(walk_dir(k));
            @(posedge Clk);
            #1;
            expect_int("wrap5_len", int'(c_len), 3);
            expect_int("wrap5_pop", $countones(c_occ), 3);
            expect_int("wrap5_alive", int'(c_dead), 0);
        end
        @(negedge Clk);
        Step3 = 1'b0;
        Dv2 = 1'b0;
        expect_int("wrap5_head_x", int'(c_hx), 9);
        expect_int("wrap5_head_y", int'(c_hy), 7);
        expect_int("wrap5_tail_x", int'(c_tx), 8);
        expect_int("wrap5_tail_y", int'(c_ty), 8);
        expect_int("win4_len_final", int'(b_len), 4);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end
endmodule
